// File: rtl/frogger_game_fsm_if.sv
// Control/status bundle between the Frogger game sequencer and the rest of the datapath.
// The slave side is the sequencer; the master side drives the button and event inputs.
interface frogger_game_fsm_if;
    logic       i_Game_Start;
    logic       i_Collided;
    logic       i_Goal_Reached;
    logic       o_Game_Active;
    logic       o_Car_Enable;
    logic       o_Frogger_Reset;
    logic [2:0] o_State;
    logic [6:0] o_Score;
    logic [1:0] o_Lives;
    logic [2:0] o_Level;
    logic       o_Win;

    modport master (
        output i_Game_Start, i_Collided, i_Goal_Reached,
        input  o_Game_Active, o_Car_Enable, o_Frogger_Reset,
        input  o_State, o_Score, o_Lives, o_Level, o_Win
    );

    modport slave (
        input  i_Game_Start, i_Collided, i_Goal_Reached,
        output o_Game_Active, o_Car_Enable, o_Frogger_Reset,
        output o_State, o_Score, o_Lives, o_Level, o_Win
    );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: state machine, score, lives, level and respawn/enable gating.
// Define FROGGER_PAUSE_EN to let a start edge pause and resume a running game.
module frogger_game_fsm #(
    parameter int c_LIVES       = 3,
    parameter int c_SCORE_LIMIT = 99,
    parameter int c_LEVEL_STEP  = 10,
    parameter int c_TICK_CYCLES = 25000000,
    parameter int c_HOLD_TICKS  = 2
) (
    input  logic i_Clk,
    input  logic i_Reset,
    frogger_game_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_RUNNING   = 3'b001,
        S_DYING     = 3'b010,
        S_SCORED    = 3'b011,
        S_CLEANUP   = 3'b100,
        S_GAME_OVER = 3'b101,
        S_PAUSED    = 3'b110
    } state_t;

    localparam int TICK_W = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
    localparam int HOLD_W = (c_HOLD_TICKS > 0) ? $clog2(c_HOLD_TICKS + 1) : 1;

    localparam logic [1:0]        LIVES_INIT  = 2'(c_LIVES);
    localparam logic [6:0]        SCORE_LIMIT = 7'(c_SCORE_LIMIT);
    localparam logic [6:0]        LEVEL_STEP  = 7'(c_LEVEL_STEP);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(c_TICK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(c_HOLD_TICKS - 1);

    state_t              state, next_state;
    logic [6:0]          score, next_score, score_inc;
    logic [1:0]          lives, next_lives;
    logic [2:0]          level, next_level;
    logic                win, next_win;
    logic                run_en;
    logic                frogger_reset;
    logic                respawn;
    logic                clear_prescaler;
    logic                start_prev;
    logic                start_edge;
    logic [TICK_W-1:0]   tick_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                tick_last;

    assign start_edge = bus.i_Game_Start & ~start_prev;
    assign tick_last  = (tick_cnt == TICK_LAST);

    always_comb begin
        next_state      = state;
        next_score      = score;
        next_lives      = lives;
        next_level      = level;
        next_win        = win;
        respawn         = 1'b0;
        clear_prescaler = 1'b0;
        score_inc       = (score < SCORE_LIMIT) ? score + 7'd1 : score;

        case (state)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    next_state = S_CLEANUP;
                    next_score = 7'd0;
                    next_lives = LIVES_INIT;
                    next_level = 3'd0;
                    next_win   = 1'b0;
                end
            end
            S_CLEANUP: begin
                next_state = S_RUNNING;
            end
            // Collision outranks a simultaneous goal; the goal is simply lost.
            S_RUNNING: begin
                if (bus.i_Collided) begin
                    next_state      = S_DYING;
                    next_lives      = lives - 2'd1;
                    clear_prescaler = 1'b1;
                end else if (bus.i_Goal_Reached) begin
                    next_state = S_SCORED;
`ifdef FROGGER_PAUSE_EN
                end else if (start_edge) begin
                    next_state = S_PAUSED;
`endif
                end
            end
            S_SCORED: begin
                next_score = score_inc;
                if ((score_inc != 7'd0) && ((score_inc % LEVEL_STEP) == 7'd0) && (level != 3'd7)) begin
                    next_level = level + 3'd1;
                end
                if (score_inc == SCORE_LIMIT) begin
                    next_state = S_GAME_OVER;
                    next_win   = 1'b1;
                end else begin
                    next_state = S_RUNNING;
                    respawn    = 1'b1;
                end
            end
            // Lives were already decremented on entry, so zero here means no respawn.
            S_DYING: begin
                if (tick_last && (hold_cnt == HOLD_LAST)) begin
                    if (lives == 2'd0) begin
                        next_state = S_GAME_OVER;
                        next_win   = 1'b0;
                    end else begin
                        next_state = S_RUNNING;
                        respawn    = 1'b1;
                    end
                end
            end
`ifdef FROGGER_PAUSE_EN
            S_PAUSED: begin
                if (start_edge) begin
                    next_state = S_RUNNING;
                end
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= S_IDLE;
            score         <= 7'd0;
            lives         <= LIVES_INIT;
            level         <= 3'd0;
            win           <= 1'b0;
            run_en        <= 1'b0;
            frogger_reset <= 1'b0;
            start_prev    <= 1'b1;
        end else begin
            state         <= next_state;
            score         <= next_score;
            lives         <= next_lives;
            level         <= next_level;
            win           <= next_win;
            run_en        <= (next_state == S_RUNNING);
            frogger_reset <= respawn | (next_state == S_CLEANUP);
            start_prev    <= bus.i_Game_Start;
        end
    end

    // Free-running tick prescaler; the hold counter only advances while dying.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || clear_prescaler) begin
            tick_cnt <= '0;
            hold_cnt <= '0;
        end else if (state != S_PAUSED) begin
            if (tick_last) begin
                tick_cnt <= '0;
                if (state == S_DYING) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign bus.o_State         = state;
    assign bus.o_Score         = score;
    assign bus.o_Lives         = lives;
    assign bus.o_Level         = level;
    assign bus.o_Win           = win;
    assign bus.o_Game_Active   = run_en;
    assign bus.o_Car_Enable    = run_en;
    assign bus.o_Frogger_Reset = frogger_reset;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Directed bench for frogger_game_fsm using small tick/hold/score parameters.
// Covers the FROGGER_PAUSE_EN build as well when that macro is defined.
module tb_frogger_game_fsm;

    localparam int LIVES        = 3;
    localparam int LIMIT        = 5;
    localparam int STEP         = 2;
    localparam int TICKS        = 4;
    localparam int HOLD         = 2;
    localparam int DYING_CYCLES = TICKS * HOLD;

    logic i_Clk = 1'b0;
    logic i_Reset;
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    int   dying_seen;

    frogger_game_fsm_if bus();

    frogger_game_fsm #(
        .c_LIVES      (LIVES),
        .c_SCORE_LIMIT(LIMIT),
        .c_LEVEL_STEP (STEP),
        .c_TICK_CYCLES(TICKS),
        .c_HOLD_TICKS (HOLD)
    ) dut (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .bus    (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // Inputs change 1 time unit after a rising edge, outputs are read at the same point.
    task automatic apply_stimulus(input logic start, input logic coll, input logic goal);
        bus.i_Game_Start   = start;
        bus.i_Collided     = coll;
        bus.i_Goal_Reached = goal;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input int score, input int lives,
                             input int level, input int win, input int en, input int fr);
        check_output({tag, ".state"}, 8'(bus.o_State), 8'(st));
        check_output({tag, ".score"}, 8'(bus.o_Score), 8'(score));
        check_output({tag, ".lives"}, 8'(bus.o_Lives), 8'(lives));
        check_output({tag, ".level"}, 8'(bus.o_Level), 8'(level));
        check_output({tag, ".win"}, 8'(bus.o_Win), 8'(win));
        check_output({tag, ".game_active"}, 8'(bus.o_Game_Active), 8'(en));
        check_output({tag, ".car_enable"}, 8'(bus.o_Car_Enable), 8'(en));
        check_output({tag, ".frogger_reset"}, 8'(bus.o_Frogger_Reset), 8'(fr));
    endtask

    initial begin
        i_Reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("reset", 3'b000, 0, LIVES, 0, 0, 0, 0);

        i_Reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("idle", 3'b000, 0, LIVES, 0, 0, 0, 0);

        // Start edge: one CLEANUP cycle with respawn, then RUNNING
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t1_cleanup", 3'b100, 0, 3, 0, 0, 0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t1_running", 3'b001, 0, 3, 0, 0, 1, 0);

        // Collision: eight DYING cycles, then respawn pulse with RUNNING
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_all("t2_dying", 3'b010, 0, 2, 0, 0, 0, 0);
        dying_seen = 1;
        for (int i = 1; i < DYING_CYCLES; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0);
            if (bus.o_State == 3'b010 && bus.o_Car_Enable == 1'b0) dying_seen++;
        end
        check_output("t2_dying_len", 8'(dying_seen), 8'(DYING_CYCLES));
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t2_respawn", 3'b001, 0, 2, 0, 0, 1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t2_run", 3'b001, 0, 2, 0, 0, 1, 0);

        // Collision and goal together: collision wins, goal dropped
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_all("t4_dying", 3'b010, 0, 1, 0, 0, 0, 0);
        repeat (DYING_CYCLES) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t4_respawn", 3'b001, 0, 1, 0, 0, 1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        // Goals three cycles apart up to the score limit
        for (int k = 1; k <= LIMIT; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1);
            check_all($sformatf("t3_scored%0d", k), 3'b011, k - 1, 1, (k - 1) / STEP, 0, 0, 0);
            apply_stimulus(1'b0, 1'b0, 1'b0);
            if (k < LIMIT) begin
                check_all($sformatf("t3_after%0d", k), 3'b001, k, 1, k / STEP, 0, 1, 1);
                apply_stimulus(1'b0, 1'b0, 1'b0);
            end else begin
                check_all("t3_win", 3'b101, LIMIT, 1, LIMIT / STEP, 1, 0, 0);
            end
        end
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_all("t3_frozen", 3'b101, LIMIT, 1, LIMIT / STEP, 1, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t3_restart", 3'b100, 0, LIVES, 0, 0, 0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t3_rerun", 3'b001, 0, LIVES, 0, 0, 1, 0);

        // Lose every life
        for (int n = 1; n <= LIVES; n++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            check_all($sformatf("t5_dying%0d", n), 3'b010, 0, LIVES - n, 0, 0, 0, 0);
            repeat (DYING_CYCLES) apply_stimulus(1'b0, 1'b0, 1'b0);
            if (n < LIVES) check_all($sformatf("t5_respawn%0d", n), 3'b001, 0, LIVES - n, 0, 0, 1, 1);
            else           check_all("t5_lose", 3'b101, 0, 0, 0, 0, 0, 0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t5_restart", 3'b100, 0, LIVES, 0, 0, 0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t6_score1", 3'b001, 1, LIVES, 0, 0, 1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0);

`ifdef FROGGER_PAUSE_EN
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t6_paused", 3'b110, 1, LIVES, 0, 0, 0, 0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_all("t6_paused_ignore", 3'b110, 1, LIVES, 0, 0, 0, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t6_resume", 3'b001, 1, LIVES, 0, 0, 1, 0);
`else
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t6_start_ignored", 3'b001, 1, LIVES, 0, 0, 1, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("t6_still_running", 3'b001, 1, LIVES, 0, 0, 1, 0);
`endif

        // Reset in the middle of a death hold
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_all("mid_dying", 3'b010, 1, LIVES - 1, 0, 0, 0, 0);
        i_Reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_all("mid_reset", 3'b000, 0, LIVES, 0, 0, 0, 0);

        // Start held through reset yields no edge
        apply_stimulus(1'b1, 1'b0, 1'b0);
        i_Reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t6_held_idle", 3'b000, 0, LIVES, 0, 0, 0, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_all("t6_new_edge", 3'b100, 0, LIVES, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
